seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV, default 1000, SHALL set the clock cycles each digit is lit (SHOW state); legal range 1..65535.
REQ-002 Parameter BLK, default 16, SHALL set the clock cycles of each inter-digit blanking gap; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 en  input  1  SHALL be the display enable; 0 forces seg and dig to 0.
REQ-006 seg1  input  7  SHALL be the least-significant-digit segment code, active-high, bit0=a .. bit6=g.
REQ-007 seg2  input  7  SHALL be the most-significant-digit segment code, same encoding.
REQ-008 upd  input  1  SHALL be a one-cycle strobe requesting capture of seg1/seg2.
REQ-009 seg  output  7  SHALL be the shared, registered, active-high segment bus.
REQ-010 dig  output  2  SHALL be the registered, one-hot, active-high digit select: bit0 = LSD, bit1 = MSD.
REQ-011 frame  output  1  SHALL pulse high for one cycle at each frame boundary.
REQ-012 pend  output  1  SHALL be high while a captured update awaits its frame boundary.

Function
REQ-013 The sequencer SHALL cycle BLANK1 -> SHOW1 -> BLANK2 -> SHOW2 -> BLANK1, with no other states.
REQ-014 A cycle counter SHALL time each state: BLANK states last exactly BLK cycles, SHOW states exactly DIV cycles; counter clears on every transition; frame length = 2*(DIV+BLK) cycles.
REQ-015 seg, dig and frame SHALL be registered and change on the same edge on which the state they reflect is entered.
REQ-016 In SHOW1 with en=1, dig=01 and seg=active LSD register; in SHOW2 with en=1, dig=10 and seg=active MSD register.
REQ-017 In BLANK1/BLANK2, dig=00 and seg=0000000 regardless of en; dig SHALL never be 11.
REQ-018 en=0 SHALL force seg=0 and dig=00 from the next edge onward; the sequencer and counter keep running, so re-enabling resumes at the current scan position without restart.
REQ-019 upd=1 SHALL load seg1/seg2 into pending registers on that edge and set pend.
REQ-020 On the SHOW2 -> BLANK1 edge: if pend=1, active registers take the pending values and pend clears; frame=1 during the first BLANK1 cycle; active digits never change mid-frame.
REQ-021 upd coinciding with the SHOW2 -> BLANK1 edge: active registers take the pending values held before that edge, pending registers take the new inputs, and pend stays 1.
REQ-022 Back-to-back upd strobes within one frame: last write wins; only one update is applied at the next boundary.
REQ-023 frame SHALL NOT pulse on the first BLANK1 after reset.

Reset
REQ-024 rst=1 on an edge SHALL force state BLANK1, counter 0, active and pending registers 0, pend=0, seg=0, dig=00, frame=0; this takes priority over upd and en.
REQ-025 rst asserted mid-frame SHALL abandon the frame and discard any pending update; after release, scanning restarts at BLANK1 cycle 0.

Verification (DIV=4, BLK=2, frame = 12 cycles; cycle 0 = first edge after rst release)
REQ-026 Scan timing: en=1, upd with seg1=7'h06, seg2=7'h5B during cycle 0 -> cycles 0-1 dig=00; 2-5 dig=01, seg=0; 6-7 dig=00; 8-11 dig=10, seg=0; cycle 12 frame=1, pend 1->0; cycles 14-17 dig=01, seg=7'h06; cycles 20-23 dig=10, seg=7'h5B.
REQ-027 Mid-frame update: upd with seg1=7'h3F at cycle 15 -> pend=1, seg stays 7'h06 through cycle 17; seg=7'h3F from cycle 26.
REQ-028 Boundary collision: upd with seg1=7'h66 on the SHOW2 -> BLANK1 edge while pend=1 holding 7'h3F -> this frame shows 7'h3F, pend stays 1, the next frame shows 7'h66.
REQ-029 Enable: en=0 during cycles 14-16 -> seg=0 and dig=00 for those cycles; the next edge restores dig=01 with the frame timing unshifted.
REQ-030 Reset mid-operation: rst at cycle 9 with pend=1 -> next edge seg=0, dig=00, pend=0; after release no frame pulse at its first BLANK1 and active digits = 0.
REQ-031 Invariant checks on every cycle: dig never 11; seg=0 whenever dig=00; frame high for at most 1 consecutive cycle.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps between digits
// and frame-synchronous double-buffered digit updates.
module seg_scan_mux #(
    parameter int unsigned DIV = 1000,
    parameter int unsigned BLK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic       upd,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       frame,
    output logic       pend
);

    typedef enum logic [1:0] {
        BLANK1,
        SHOW1,
        BLANK2,
        SHOW2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLK - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  act_lsd_q, act_lsd_d;
    logic [6:0]  act_msd_q, act_msd_d;
    logic [6:0]  pnd_lsd_q, pnd_lsd_d;
    logic [6:0]  pnd_msd_q, pnd_msd_d;
    logic        pend_q, pend_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  dig_q, dig_d;
    logic        frame_q, frame_d;
    logic        last;
    logic        wrap;

    always_comb begin
        state_d   = state_q;
        cnt_d     = 16'(cnt_q + 16'd1);
        act_lsd_d = act_lsd_q;
        act_msd_d = act_msd_q;
        pnd_lsd_d = pnd_lsd_q;
        pnd_msd_d = pnd_msd_q;
        seg_d     = '0;
        dig_d     = '0;

        if (state_q == BLANK1 || state_q == BLANK2) begin
            last = (cnt_q == BLK_LAST);
        end else begin
            last = (cnt_q == DIV_LAST);
        end

        if (last) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK1:  state_d = SHOW1;
                SHOW1:   state_d = BLANK2;
                BLANK2:  state_d = SHOW2;
                default: state_d = BLANK1;
            endcase
        end

        wrap = last && (state_q == SHOW2);

        // Active digits swap only at the frame wrap, from the pending copy held
        // before this edge; a coincident strobe refills pending and keeps pend set.
        if (wrap && pend_q) begin
            act_lsd_d = pnd_lsd_q;
            act_msd_d = pnd_msd_q;
        end
        if (upd) begin
            pnd_lsd_d = seg1;
            pnd_msd_d = seg2;
        end
        pend_d  = upd || (pend_q && !wrap);
        frame_d = wrap;

        if (en && state_d == SHOW1) begin
            dig_d = 2'b01;
            seg_d = act_lsd_d;
        end else if (en && state_d == SHOW2) begin
            dig_d = 2'b10;
            seg_d = act_msd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BLANK1;
            cnt_q     <= '0;
            act_lsd_q <= '0;
            act_msd_q <= '0;
            pnd_lsd_q <= '0;
            pnd_msd_q <= '0;
            pend_q    <= 1'b0;
            seg_q     <= '0;
            dig_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_lsd_q <= act_lsd_d;
            act_msd_q <= act_msd_d;
            pnd_lsd_q <= pnd_lsd_d;
            pnd_msd_q <= pnd_msd_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dig   = dig_q;
    assign frame = frame_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a positional frame model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_seg_scan_mux;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLK   = 2;
    localparam int unsigned FRAME = 2 * (DIV + BLK);

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic       upd;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       frame;
    logic       pend;

    seg_scan_mux #(.DIV(DIV), .BLK(BLK)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .seg1 (seg1),
        .seg2 (seg2),
        .upd  (upd),
        .seg  (seg),
        .dig  (dig),
        .frame(frame),
        .pend (pend)
    );

    typedef struct {
        logic [6:0] seg;
        logic [1:0] dig;
        logic       frame;
        logic       pend;
    } exp_t;

    exp_t expq[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          stim_done = 0;

    // Reference model: cycles since reset, the displayed and the buffered digits.
    int unsigned m_pos = 0;
    logic [6:0]  m_act1 = '0, m_act2 = '0, m_pn1 = '0, m_pn2 = '0;
    bit          m_pend = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are held through one cycle; the expectation is for the cycle that
    // begins at the following rising edge.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic [6:0] s1, input logic [6:0] s2);
        exp_t        x;
        int unsigned p;
        bit          boundary;
        @(negedge clk);
        rst = r; en = e; upd = u; seg1 = s1; seg2 = s2;
        x = '{seg: 7'd0, dig: 2'd0, frame: 1'b0, pend: 1'b0};
        if (r) begin
            m_pos  = 0;
            m_act1 = '0; m_act2 = '0; m_pn1 = '0; m_pn2 = '0;
            m_pend = 0;
        end else begin
            boundary = ((m_pos % FRAME) == FRAME - 1);
            if (boundary && m_pend) begin
                m_act1 = m_pn1;
                m_act2 = m_pn2;
            end
            m_pend = u || (m_pend && !boundary);
            if (u) begin
                m_pn1 = s1;
                m_pn2 = s2;
            end
            m_pos = m_pos + 1;
            p = m_pos % FRAME;
            x.frame = (p == 0);
            if (e && p >= BLK && p < BLK + DIV) begin
                x.dig = 2'b01;
                x.seg = m_act1;
            end else if (e && p >= 2 * BLK + DIV) begin
                x.dig = 2'b10;
                x.seg = m_act2;
            end
            x.pend = m_pend;
        end
        expq.push_back(x);
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        logic prev_frame = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                check("seg",   32'(seg),   32'(x.seg));
                check("dig",   32'(dig),   32'(x.dig));
                check("frame", 32'(frame), 32'(x.frame));
                check("pend",  32'(pend),  32'(x.pend));
                check("dig_not_11", 32'(dig == 2'b11), 0);
                check("seg_blank_when_dig0", 32'(dig == 2'b00 && seg != 7'd0), 0);
                check("frame_single", 32'(frame && prev_frame), 0);
                prev_frame = frame;
            end
        end
    end

    // Stimulus
    initial begin
        int unsigned burst;
        logic        e, u, r;
        rst = 1'b1; en = 1'b1; upd = 1'b0; seg1 = '0; seg2 = '0;
        step(1, 1, 0, 7'h00, 7'h00);
        // Directed scenarios; c is the cycle in which the inputs are held.
        for (int c = 0; c < 90; c++) begin
            r = (c == 57);
            e = !((c >= 49 && c <= 51) || (c >= 70 && c <= 72));
            if (c == 0)       step(r, e, 1, 7'h06, 7'h5B);
            else if (c == 15) step(r, e, 1, 7'h3F, 7'h5B);
            else if (c == 23) step(r, e, 1, 7'h66, 7'h4F);
            else if (c == 30) step(r, e, 1, 7'h11, 7'h22);
            else if (c == 31) step(r, e, 1, 7'h33, 7'h44);
            else if (c == 56) step(r, e, 1, 7'h7F, 7'h7F);
            else              step(r, e, 0, 7'h00, 7'h00);
        end
        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 8);
            e = (burst == 0);
            if (burst != 0) burst--;
            u = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(r, e, u, 7'($urandom), 7'($urandom));
        end
        step(0, 1, 0, 7'h00, 7'h00);
        stim_done = 1;
    end

    initial begin
        int unsigned waited;
        wait (stim_done);
        waited = 0;
        while (expq.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
